// File: rtl/breakout_pkg.sv
// breakout_pkg: shared Breakout screen/brick geometry, row colours and brick indexing.
package breakout_pkg;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int BLOCK_WIDTH = 80;
  localparam int BLOCK_HEIGHT = 30;
  localparam int FIRST_COL_X = 40;
  localparam int COL_PITCH = 120;
  localparam int FIRST_ROW_Y = 40;
  localparam int ROW_PITCH = 50;
  localparam int NUM_BRICKS = 25;
  localparam int NUM_COLS = 5;
  localparam int NUM_ROWS = 5;
  localparam logic [7:0] ROW0_COLOR = 8'hE0;
  localparam logic [7:0] ROW1_COLOR = 8'hEC;
  localparam logic [7:0] ROW2_COLOR = 8'hFC;
  localparam logic [7:0] ROW3_COLOR = 8'h1C;
  localparam logic [7:0] ROW4_COLOR = 8'h03;
  typedef enum logic {PLAY, CLEARED} field_state_t;
  function automatic logic [4:0] brick_index(input int r, input int c);
    return 5'(r * NUM_COLS + c);
  endfunction
  function automatic logic [7:0] row_color(input int r);
    return r == 0 ? ROW0_COLOR : r == 1 ? ROW1_COLOR : r == 2 ? ROW2_COLOR :
           r == 3 ? ROW3_COLOR : ROW4_COLOR;
  endfunction
endpackage

// File: rtl/brick_hit_decode.sv
// brick_hit_decode: pixel stage 1, registers one-hot row/col hits and the in-brick flag.
module brick_hit_decode
  import breakout_pkg::*;
#(
  parameter int BLOCK_WIDTH  = 80,
  parameter int BLOCK_HEIGHT = 30,
  parameter int FIRST_COL_X  = 40,
  parameter int COL_PITCH    = 120,
  parameter int FIRST_ROW_Y  = 40,
  parameter int ROW_PITCH    = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  output logic [4:0] row_hit,
  output logic [4:0] col_hit,
  output logic       in_brick
);
  logic [4:0] row_d, col_d;
  // 11-bit bounds keep the upper edge of the last column from wrapping
  for (genvar i = 0; i < NUM_COLS; i++) begin : g_col
    localparam logic [10:0] LO = 11'(FIRST_COL_X + i * COL_PITCH);
    assign col_d[i] = {1'b0, pixel_x} >= LO && {1'b0, pixel_x} < LO + 11'(BLOCK_WIDTH);
  end
  for (genvar i = 0; i < NUM_ROWS; i++) begin : g_row
    localparam logic [10:0] LO = 11'(FIRST_ROW_Y + i * ROW_PITCH);
    assign row_d[i] = {1'b0, pixel_y} >= LO && {1'b0, pixel_y} < LO + 11'(BLOCK_HEIGHT);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      row_hit  <= '0;
      col_hit  <= '0;
      in_brick <= 1'b0;
    end else begin
      row_hit  <= row_d;
      col_hit  <= col_d;
      in_brick <= |row_d && |col_d;
    end
  end
endmodule

// File: rtl/brick_field.sv
// brick_field: Breakout wall mask, brick count, row-weighted score, level-clear FSM
// and the 2-stage brick pixel query pipeline.
module brick_field
  import breakout_pkg::*;
#(
  parameter int BLOCK_WIDTH  = 80,
  parameter int BLOCK_HEIGHT = 30,
  parameter int FIRST_COL_X  = 40,
  parameter int COL_PITCH    = 120,
  parameter int FIRST_ROW_Y  = 40,
  parameter int ROW_PITCH    = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       erase_enable,
  input  logic [5:0] e_pos,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  output logic       brick_on,
  output logic [7:0] brick_color,
  output logic [4:0] bricks_left,
  output logic [6:0] score,
  output logic       level_clear
);
  field_state_t state, state_d;
  logic [NUM_BRICKS-1:0] active, hit_mask;
  logic [4:0] row_hit, col_hit;
  logic in_brick, erase_ok, on_d;
  logic [5:0] e_row;
  logic [7:0] color_d;
  brick_hit_decode #(
    .BLOCK_WIDTH(BLOCK_WIDTH), .BLOCK_HEIGHT(BLOCK_HEIGHT), .FIRST_COL_X(FIRST_COL_X),
    .COL_PITCH(COL_PITCH), .FIRST_ROW_Y(FIRST_ROW_Y), .ROW_PITCH(ROW_PITCH)
  ) u_decode (
    .clk(clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .row_hit(row_hit), .col_hit(col_hit), .in_brick(in_brick)
  );
  assign e_row = e_pos / 6'd5;
  assign erase_ok = state == PLAY && erase_enable && e_pos <= 6'd24 && active[e_pos[4:0]];
  assign level_clear = state == CLEARED;
  always_comb state_d = (erase_ok && bricks_left == 5'd1) ? CLEARED : state;
  always_ff @(posedge clk) begin
    if (reset) state <= PLAY;
    else state <= state_d;
  end
  // Row r is worth 5-r points, so a full clear totals exactly 75
  always_ff @(posedge clk) begin
    if (reset) begin
      active      <= '1;
      bricks_left <= 5'(NUM_BRICKS);
      score       <= '0;
    end else if (erase_ok) begin
      active[e_pos[4:0]] <= 1'b0;
      bricks_left        <= bricks_left - 5'd1;
      score              <= score + 7'(6'd5 - e_row);
    end
  end
  always_comb begin
    hit_mask = '0;
    color_d  = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (row_hit[r]) color_d = row_color(r);
      for (int c = 0; c < NUM_COLS; c++) hit_mask[brick_index(r, c)] = row_hit[r] & col_hit[c];
    end
  end
  assign on_d = in_brick && |(hit_mask & active);
  always_ff @(posedge clk) begin
    if (reset) begin
      brick_on    <= 1'b0;
      brick_color <= '0;
    end else begin
      brick_on    <= on_d;
      brick_color <= on_d ? color_d : 8'h00;
    end
  end
endmodule

// File: doc/brick_field.md
# brick_field

Holds the 25-brick wall state for the Breakout datapath and sits directly downstream of the ball block. It consumes the ball block's one-cycle erase pulse and brick index, clears the brick, and keeps a live brick count, a row-weighted score and a level-clear flag. It also answers VGA pixel queries through a 2-stage pipeline, giving brick-on and brick colour for the pixel mixer.

## Interface
Parameters:
- `BLOCK_WIDTH`, 80, brick width in pixels
- `BLOCK_HEIGHT`, 30, brick height in pixels
- `FIRST_COL_X`, 40, left edge of column 0
- `COL_PITCH`, 120, column-to-column distance (80 brick + 40 spacing)
- `FIRST_ROW_Y`, 40, top edge of row 0
- `ROW_PITCH`, 50, row-to-row distance (rows at y = 40/90/140/190/240)

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high; restores the full wall and zeroes the score
- `erase_enable`  in  1  one-cycle pulse from the ball block: erase brick `e_pos`
- `e_pos`  in  6  brick index = row*5 + col, valid range 0..24
- `pixel_x`  in  10  current VGA column
- `pixel_y`  in  10  current VGA row
- `brick_on`  out  1  queried pixel lies inside an active brick (2-cycle latency)
- `brick_color`  out  8  RRRGGGBB colour for that pixel; 0 when `brick_on` = 0
- `bricks_left`  out  5  number of active bricks, 0..25
- `score`  out  7  accumulated points, 0..75
- `level_clear`  out  1  high once every brick is gone

## Operation
- Wall state is a 25-bit `active` mask. Index mapping: row r in 0..4, col c in 0..4, index = 5r + c.
- The mask has its own state; the ball block's internal copy is not used by this block.
- FSM has two states, PLAY and CLEARED. Reset enters PLAY.
- In PLAY, `erase_enable` = 1 counts as a valid erase only when `e_pos` ≤ 24 and `active[e_pos]` = 1. A valid erase does three things:
  - clears the mask bit
  - decrements `bricks_left`
  - adds (5 − r) to `score`: row 0 is worth 5 points, row 4 is worth 1
- Any other erase is ignored: out-of-range index, already-cleared brick, or state CLEARED. An ignored erase changes no state.
- PLAY → CLEARED on the edge where a valid erase takes `bricks_left` from 1 to 0.
- CLEARED is held until `reset`. `level_clear` = (state == CLEARED).
- Pixel hit test, for row r and col c:
  - x is in [FIRST_COL_X + c·COL_PITCH, … + BLOCK_WIDTH)
  - y is in [FIRST_ROW_Y + r·ROW_PITCH, … + BLOCK_HEIGHT)
  - lower bound inclusive, upper bound exclusive
- Row colours: r0 8'hE0, r1 8'hEC, r2 8'hFC, r3 8'h1C, r4 8'h03.
- Width rules:
  - all coordinate comparisons are unsigned 10-bit
  - bound arithmetic uses 11 bits, so no wrap at 640
  - `score` saturates by construction (maximum 75)

## Timing
- Reset values:
  - `active` = all ones
  - `bricks_left` = 25
  - `score` = 0
  - `level_clear` = 0
  - `brick_on` = 0
  - `brick_color` = 0
  - pipeline valid bits = 0
- Erase latency: sampled at edge N. Mask, count and score are updated after edge N. `level_clear` rises after the same edge N that removes the last brick.
- Back-to-back erases on consecutive cycles are each honoured. A second pulse for the same index is ignored because the mask is already clear.
- Pixel pipeline:
  - stage 1 (edge N): registers row-hit (5 bits), col-hit (5 bits) and in-brick flag from `pixel_x`/`pixel_y`
  - stage 2 (edge N+1): ANDs with `active`, then registers `brick_on` and `brick_color`
  - outputs are valid after edge N+1, i.e. 2-cycle latency
- Stage 2 reads the mask as it stands on that edge. A brick erased after the same edge disappears starting with the next query.
- `reset` asserted mid-game or with a simultaneous erase: reset wins and the erase is dropped. Pipeline outputs go to 0 on the next edge.

## Structure
- Shared package `breakout_pkg`:
  - the screen and brick geometry constants listed above
  - `NUM_BRICKS` = 25, `NUM_COLS` = 5
  - the row colour constants
  - the brick-index function (r, c) → 5r + c
- One sub-module, `brick_hit_decode`: pipeline stage 1, pixel → registered row/col one-hot plus in-brick flag.
- Mask, counters, FSM and stage 2 live in `brick_field`.

## Test plan
- Reset, then query pixel (45, 45) → after 2 cycles `brick_on` = 1, `brick_color` = 8'hE0; `bricks_left` = 25, `score` = 0.
- Erase pulse, `e_pos` = 0 → `bricks_left` = 24, `score` = 5; re-query (45, 45) → `brick_on` = 0. Repeat erase 0 → no change.
- Erase `e_pos` = 24 then `e_pos` = 30 → `score` += 1 only, `bricks_left` = 23; pixel (525, 245) → `brick_on` = 0.
- Edge pixels:
  - (39, 40) → 0
  - (40, 40) → 1
  - (119, 69) → 1
  - (120, 69) → 0
  - (160, 90) → 1, colour 8'hEC
- Erase all 25 on consecutive cycles → `score` = 75, `level_clear` rises after the 25th edge; a further erase changes nothing.
- Reset asserted in the same cycle as an erase, mid-game → full wall restored, `score` = 0, `level_clear` = 0.
